adder_apb_regbank: RTL
======================

// Module: adder_apb_regbank
// PURPOSE
//  APB3 slave register bank that fronts the adder control FSM. Holds operands,
//  START/IRQ_EN control bits, sticky DONE status and captured result. Drives
//  o_start to the control FSM; consumes its busy/en_ctrl_write/rst_start/done.
//  Sits between the APB interconnect and the control/adder datapath.
// PARAMETERS
//  DATA_W       32  operand width; result is DATA_W+1 (carry in bit DATA_W)
//  ADDR_W       8   PADDR width; byte address, word-aligned decode on [4:2]
//  WAIT_STATES  0   extra ACCESS cycles before PREADY (0..15)
// PORTS
//  ACLK              in   1         clock
//  ARST              in   1         synchronous reset, active-high
//  PSEL              in   1         APB select
//  PENABLE           in   1         APB access phase
//  PWRITE            in   1         1=write, 0=read
//  PADDR             in   ADDR_W    byte address
//  PWDATA            in   DATA_W    write data
//  PRDATA            out  DATA_W    read data, valid when PREADY=1
//  PREADY            out  1         transfer completes this cycle
//  PSLVERR           out  1         error, valid when PREADY=1
//  i_is_busy         in   1         control FSM busy
//  i_en_ctrl_write   in   1         capture i_result this cycle
//  i_rst_start       in   1         clear START
//  i_result_is_done  in   1         set sticky DONE
//  i_result          in   DATA_W+1  adder output
//  o_start           out  1         START bit to control FSM
//  o_op_a, o_op_b    out  DATA_W    operand registers
//  o_irq             out  1         DONE & IRQ_EN
// BEHAVIOUR
//  Register map (PADDR[4:2]): 0 CTRL RW {IRQ_EN[1],START[0]}; 1 STATUS
//   {DONE[1] W1C, BUSY[0] RO}; 2 OPA RW; 3 OPB RW; 4 RESULT_LO RO [DATA_W-1:0];
//   5 RESULT_HI RO {carry[0]}; 6,7 unmapped.
//  Reset: PRDATA=0, PREADY=0, PSLVERR=0, START=0, IRQ_EN=0, DONE=0, OPA=OPB=0,
//   RESULT=0, o_irq=0.
//  APB FSM: IDLE -> SETUP on PSEL&!PENABLE -> ACCESS on PENABLE. Wait counter
//   loads WAIT_STATES on SETUP; PREADY=1 (registered) when counter=0 in ACCESS,
//   for exactly one cycle, then -> IDLE (or SETUP if PSEL&!PENABLE). WAIT_STATES=0:
//   PREADY in first ACCESS cycle. PSEL dropped mid-ACCESS -> IDLE, no side effect.
//  Commit: register writes/W1C take effect on ACLK edge where PSEL&PENABLE&PREADY.
//  PRDATA/PSLVERR driven alongside PREADY; 0 otherwise.
//  PSLVERR=1, no state change: unmapped address; write to STATUS[0], RESULT_*;
//   write to CTRL/OPA/OPB while i_is_busy=1 (reads always allowed).
//  START: set by CTRL write with PWDATA[0]=1 and !i_is_busy; cleared by
//   i_rst_start. Writing 0 never clears a pending START. i_rst_start wins if same
//   cycle. o_start = START register (no combinational path from APB).
//  RESULT: captured from i_result on i_en_ctrl_write; holds otherwise.
//  DONE: set on i_result_is_done; cleared by STATUS write with PWDATA[1]=1; set
//   wins on same-cycle collision. Setting START does not clear DONE.
//  BUSY readback = i_is_busy sampled in the cycle PRDATA is produced.
//  Reset mid-transfer: APB FSM to IDLE, PREADY low next cycle, no commit.
// TESTING
//  Write OPA=5, OPB=7, CTRL=1 -> o_start=1 one cycle after commit; after done
//   pulse RESULT_LO=12, RESULT_HI=0, STATUS=0b10.
//  OPA=OPB=0xFFFFFFFF run -> RESULT_LO=0xFFFFFFFE, RESULT_HI=1.
//  Write OPA=9 while i_is_busy=1 -> PSLVERR=1, OPA unchanged on readback.
//  IRQ_EN=1, done pulse -> o_irq=1; W1C STATUS=0x2 same cycle as new done
//   pulse -> DONE stays 1; W1C alone -> DONE=0, o_irq=0.
//  WAIT_STATES=3: read OPB -> PREADY asserts 4th ACCESS cycle; read addr 0x18
//   -> PSLVERR=1, PRDATA=0.
//  ARST asserted during ACCESS of CTRL write -> START=0, no PREADY, all regs 0.

Source files
------------

// File: rtl/adder_apb_regbank_if.sv
// adder_apb_regbank_if: APB3 bus bundle between interconnect master and the adder register bank.
interface adder_apb_regbank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/adder_apb_regbank.sv
// adder_apb_regbank: APB3 register bank holding operands, START/IRQ_EN, sticky DONE and adder result.
module adder_apb_regbank #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                ACLK,
  input  logic                ARST,
  adder_apb_regbank_if.slave  apb,
  input  logic                i_is_busy,
  input  logic                i_en_ctrl_write,
  input  logic                i_rst_start,
  input  logic                i_result_is_done,
  input  logic [DATA_W:0]     i_result,
  output logic                o_start,
  output logic [DATA_W-1:0]   o_op_a,
  output logic [DATA_W-1:0]   o_op_b,
  output logic                o_irq
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic fire, setup_ph, access_ph, counting, err, commit, wr;
  logic irq_en, done;
  logic [DATA_W:0] result;
  logic [DATA_W-1:0] rd;
  logic [2:0] idx;
  logic unused_addr;
  assign idx         = apb.PADDR[4:2];
  assign unused_addr = ^{apb.PADDR[ADDR_W-1:5], apb.PADDR[1:0]};
  assign setup_ph    = apb.PSEL & ~apb.PENABLE;
  assign access_ph   = apb.PSEL & apb.PENABLE;
  assign counting    = (state != IDLE) & access_ph & ~apb.PREADY;
  // PSLVERR is registered with PREADY, so a flagged transfer never commits
  assign commit      = access_ph & apb.PREADY & ~apb.PSLVERR;
  assign wr          = commit & apb.PWRITE;
  assign o_irq       = done & irq_en;
  always_comb begin
    state_nx = counting ? ACCESS : setup_ph ? SETUP : IDLE;
    cnt_nx   = counting ? cnt - 4'd1 : setup_ph ? 4'(WAIT_STATES) : cnt;
    fire     = counting ? (cnt == 4'd1) : setup_ph & (WAIT_STATES == 0);
  end
  always_comb begin
    err = (idx[2] & idx[1]) |
          (apb.PWRITE & ((idx == 3'd4) | (idx == 3'd5) | ((idx == 3'd1) & apb.PWDATA[0]) |
                         (i_is_busy & ((idx == 3'd0) | (idx == 3'd2) | (idx == 3'd3)))));
    rd  = (idx == 3'd0) ? {{(DATA_W-2){1'b0}}, irq_en, o_start} :
          (idx == 3'd1) ? {{(DATA_W-2){1'b0}}, done, i_is_busy} :
          (idx == 3'd2) ? o_op_a :
          (idx == 3'd3) ? o_op_b :
          (idx == 3'd4) ? result[DATA_W-1:0] :
          (idx == 3'd5) ? {{(DATA_W-1){1'b0}}, result[DATA_W]} : '0;
  end
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state       <= IDLE;
      cnt         <= '0;
      apb.PREADY  <= 1'b0;
      apb.PRDATA  <= '0;
      apb.PSLVERR <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      apb.PREADY  <= fire;
      apb.PRDATA  <= (fire & ~apb.PWRITE & ~err) ? rd : '0;
      apb.PSLVERR <= fire & err;
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      o_start <= 1'b0;
      irq_en  <= 1'b0;
      done    <= 1'b0;
      o_op_a  <= '0;
      o_op_b  <= '0;
      result  <= '0;
    end else begin
      o_start <= i_rst_start ? 1'b0 : (wr & (idx == 3'd0) & apb.PWDATA[0] & ~i_is_busy) ? 1'b1 : o_start;
      irq_en  <= (wr & (idx == 3'd0)) ? apb.PWDATA[1] : irq_en;
      o_op_a  <= (wr & (idx == 3'd2)) ? apb.PWDATA : o_op_a;
      o_op_b  <= (wr & (idx == 3'd3)) ? apb.PWDATA : o_op_b;
      done    <= i_result_is_done | (done & ~(wr & (idx == 3'd1) & apb.PWDATA[1]));
      result  <= i_en_ctrl_write ? i_result : result;
    end
  end
endmodule
